// File: rtl/fod_dcw_pkg.sv
// Shared constants, FSM encoding and lane pack/unpack helpers for the FOD DCW
// generator and its downstream retimer.
package fod_dcw_pkg;

  localparam int unsigned FRAC_W  = 16;
  localparam int unsigned INT_W   = 7;
  localparam int unsigned DTC_W   = 10;
  localparam int unsigned MMD_MIN = 4;
  localparam int unsigned LANES   = 4;

  localparam logic [INT_W-1:0] MMD_MIN_W = INT_W'(MMD_MIN);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } fsm_e;

  typedef logic [INT_W-1:0] mmd_w_t;
  typedef logic [DTC_W-1:0] dtc_w_t;

  // Lane k occupies [W*(k+1)-1 -: W]; lane 0 is the earliest sub-step.
  function automatic logic [LANES*INT_W-1:0] pack_mmd(input mmd_w_t lane [LANES]);
    logic [LANES*INT_W-1:0] bus;
    bus = '0;
    for (int unsigned k = 0; k < LANES; k++) bus[INT_W*k +: INT_W] = lane[k];
    return bus;
  endfunction

  function automatic logic [LANES*DTC_W-1:0] pack_dtc(input dtc_w_t lane [LANES]);
    logic [LANES*DTC_W-1:0] bus;
    bus = '0;
    for (int unsigned k = 0; k < LANES; k++) bus[DTC_W*k +: DTC_W] = lane[k];
    return bus;
  endfunction

  function automatic mmd_w_t mmd_of(input logic [LANES*INT_W-1:0] bus, input int unsigned k);
    return bus[INT_W*k +: INT_W];
  endfunction

  function automatic dtc_w_t dtc_of(input logic [LANES*DTC_W-1:0] bus, input int unsigned k);
    return bus[DTC_W*k +: DTC_W];
  endfunction

endpackage

// File: rtl/fod_dcw_lane.sv
// Per-lane stage-2 datapath: MMD clamp, KDTC scaling and retimer edge select.
module fod_dcw_lane
  import fod_dcw_pkg::*;
(
  input  logic [INT_W-1:0] fcw_int_i,
  input  logic             carry_i,
  input  logic [DTC_W-1:0] res_i,
  input  logic [DTC_W-1:0] kdtc_i,
  input  logic [DTC_W-1:0] rt_th_i,
  output logic [INT_W-1:0] mmd_o,
  output logic [DTC_W-1:0] dtc_o,
  output logic             rt_o
);

  logic [INT_W:0]     mmd_sum;
  logic [2*DTC_W-1:0] prod;

  always_comb begin
    mmd_sum = {1'b0, fcw_int_i} + {{INT_W{1'b0}}, carry_i};
    if (mmd_sum[INT_W]) begin
      mmd_o = '1;
    end else if (mmd_sum < {1'b0, MMD_MIN_W}) begin
      mmd_o = MMD_MIN_W;
    end else begin
      mmd_o = mmd_sum[INT_W-1:0];
    end
    prod  = {{DTC_W{1'b0}}, res_i} * {{DTC_W{1'b0}}, kdtc_i};
    dtc_o = prod[2*DTC_W-1:DTC_W];
    rt_o  = (dtc_o >= rt_th_i);
  end

endmodule

// File: rtl/fod_dcw_gen.sv
// FOD DCW generator: 4 sub-steps per clock of a fractional phase accumulator,
// emitting MMD divide words, DTC codes and retimer edge selects per lane.
module fod_dcw_gen
  import fod_dcw_pkg::*;
(
  input  logic                   DIG_CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   FCW_LOAD,
  input  logic [INT_W-1:0]       FCW_INT,
  input  logic [FRAC_W-1:0]      FCW_FRAC,
  input  logic [DTC_W-1:0]       KDTC,
  input  logic [DTC_W-1:0]       RT_TH,
  output logic [LANES*INT_W-1:0] MMD_DCW_X4,
  output logic [LANES*DTC_W-1:0] DTC_DCW_X4,
  output logic [LANES-1:0]       RT_DCW_X4,
  output logic                   DCW_VLD
);

  localparam logic [LANES*INT_W-1:0] MMD_IDLE = {LANES{MMD_MIN_W}};

  fsm_e                   state_q;
  logic                   fill_q;
  logic [FRAC_W-1:0]      acc_q, acc_d;
  logic [INT_W-1:0]       int_q, s1_int_q;
  logic [FRAC_W-1:0]      frac_q;
  logic [DTC_W-1:0]       kdtc_q, th_q, s1_kdtc_q, s1_th_q;
  logic [LANES-1:0]       carry_q, carry_d;
  dtc_w_t                 res_q [LANES];
  dtc_w_t                 res_d [LANES];
  mmd_w_t                 lane_mmd [LANES];
  dtc_w_t                 lane_dtc [LANES];
  logic [LANES-1:0]       lane_rt;
  logic [LANES*INT_W-1:0] mmd_d, mmd_q;
  logic [LANES*DTC_W-1:0] dtc_d, dtc_q;
  logic [LANES-1:0]       rt_q;
  logic                   vld_q;
  logic [FRAC_W:0]        sum;
  logic                   prev_b;

  // Carries come from the parity of bit FRAC_W between consecutive sums,
  // so one guard bit gives the same result as wider arithmetic.
  always_comb begin
    sum     = {1'b0, acc_q};
    prev_b  = 1'b0;
    carry_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum        = sum + {1'b0, frac_q};
      carry_d[k] = sum[FRAC_W] ^ prev_b;
      prev_b     = sum[FRAC_W];
      res_d[k]   = sum[FRAC_W-1 -: DTC_W];
    end
    acc_d = sum[FRAC_W-1:0];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fod_dcw_lane u_lane (
      .fcw_int_i (s1_int_q),
      .carry_i   (carry_q[k]),
      .res_i     (res_q[k]),
      .kdtc_i    (s1_kdtc_q),
      .rt_th_i   (s1_th_q),
      .mmd_o     (lane_mmd[k]),
      .dtc_o     (lane_dtc[k]),
      .rt_o      (lane_rt[k])
    );
  end

  assign mmd_d = pack_mmd(lane_mmd);
  assign dtc_d = pack_dtc(lane_dtc);

  // INT/KDTC/RT_TH travel with stage 1 so a load never mixes old and new words.
  always_ff @(posedge DIG_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      fill_q    <= 1'b0;
      acc_q     <= '0;
      int_q     <= '0;
      frac_q    <= '0;
      kdtc_q    <= '0;
      th_q      <= '0;
      s1_int_q  <= '0;
      s1_kdtc_q <= '0;
      s1_th_q   <= '0;
      carry_q   <= '0;
      for (int unsigned k = 0; k < LANES; k++) res_q[k] <= '0;
      mmd_q     <= MMD_IDLE;
      dtc_q     <= '0;
      rt_q      <= '0;
      vld_q     <= 1'b0;
    end else begin
      if (FCW_LOAD) begin
        int_q  <= FCW_INT;
        frac_q <= FCW_FRAC;
        kdtc_q <= KDTC;
        th_q   <= RT_TH;
      end
      case (state_q)
        IDLE: begin
          acc_q  <= '0;
          fill_q <= 1'b0;
          if (EN) state_q <= FILL;
        end
        FILL, RUN: begin
          if (!EN) begin
            state_q <= IDLE;
            fill_q  <= 1'b0;
            acc_q   <= '0;
            mmd_q   <= MMD_IDLE;
            dtc_q   <= '0;
            rt_q    <= '0;
            vld_q   <= 1'b0;
          end else begin
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            res_q     <= res_d;
            s1_int_q  <= int_q;
            s1_kdtc_q <= kdtc_q;
            s1_th_q   <= th_q;
            fill_q    <= 1'b1;
            if (state_q == RUN || fill_q) begin
              state_q <= RUN;
              mmd_q   <= mmd_d;
              dtc_q   <= dtc_d;
              rt_q    <= lane_rt;
              vld_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MMD_DCW_X4 = mmd_q;
  assign DTC_DCW_X4 = dtc_q;
  assign RT_DCW_X4  = rt_q;
  assign DCW_VLD    = vld_q;

endmodule

// File: tb/tb_fod_dcw_gen.sv
// Scoreboard bench for fod_dcw_gen: directed runs push hand-computed lane
// bundles; a monitor pops and compares on every DCW_VLD cycle.
module tb_fod_dcw_gen;
  import fod_dcw_pkg::*;

  logic                   DIG_CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   EN = 1'b0;
  logic                   FCW_LOAD = 1'b0;
  logic [INT_W-1:0]       FCW_INT = '0;
  logic [FRAC_W-1:0]      FCW_FRAC = '0;
  logic [DTC_W-1:0]       KDTC = '0;
  logic [DTC_W-1:0]       RT_TH = '0;
  logic [LANES*INT_W-1:0] MMD_DCW_X4;
  logic [LANES*DTC_W-1:0] DTC_DCW_X4;
  logic [LANES-1:0]       RT_DCW_X4;
  logic                   DCW_VLD;

  fod_dcw_gen dut (
    .DIG_CLK    (DIG_CLK),
    .RST        (RST),
    .EN         (EN),
    .FCW_LOAD   (FCW_LOAD),
    .FCW_INT    (FCW_INT),
    .FCW_FRAC   (FCW_FRAC),
    .KDTC       (KDTC),
    .RT_TH      (RT_TH),
    .MMD_DCW_X4 (MMD_DCW_X4),
    .DTC_DCW_X4 (DTC_DCW_X4),
    .RT_DCW_X4  (RT_DCW_X4),
    .DCW_VLD    (DCW_VLD)
  );

  always #5 DIG_CLK = ~DIG_CLK;

  typedef struct {
    logic [27:0] mmd;
    logic [39:0] dtc;
    logic [3:0]  rt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam logic [27:0] MMD_RST = {4{7'd4}};

  function automatic exp_t mk(input int m0, m1, m2, m3, d0, d1, d2, d3,
                              input int r0, r1, r2, r3, input string tag);
    exp_t e;
    e.mmd = {7'(m3), 7'(m2), 7'(m1), 7'(m0)};
    e.dtc = {10'(d3), 10'(d2), 10'(d1), 10'(d0)};
    e.rt  = {1'(r3), 1'(r2), 1'(r1), 1'(r0)};
    e.tag = tag;
    return e;
  endfunction

  task automatic tick();
    @(negedge DIG_CLK);
  endtask

  task automatic load(input int i, input int f, input int k, input int t);
    FCW_INT  = 7'(i);
    FCW_FRAC = 16'(f);
    KDTC     = 10'(k);
    RT_TH    = 10'(t);
    FCW_LOAD = 1'b1;
    tick();
    FCW_LOAD = 1'b0;
  endtask

  task automatic check_vld(input string tag, input logic want);
    vectors++;
    if (DCW_VLD !== want) begin
      miscompares++;
      $display("FAIL %s: got vld=%b want vld=%b", tag, DCW_VLD, want);
    end
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if (DCW_VLD !== 1'b0 || MMD_DCW_X4 !== MMD_RST || DTC_DCW_X4 !== '0 || RT_DCW_X4 !== '0) begin
      miscompares++;
      $display("FAIL %s: got vld=%b mmd=%h dtc=%h rt=%b, want vld=0 mmd=%h dtc=0 rt=0",
               tag, DCW_VLD, MMD_DCW_X4, DTC_DCW_X4, RT_DCW_X4, MMD_RST);
    end
  endtask

  // Caller sits at a negedge; EN rises here, VLD is checked through FILL into RUN,
  // EN drops after n valid cycles and the idle values are checked after that edge.
  task automatic run(input exp_t e, input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(e);
    EN = 1'b1;
    for (int unsigned c = 1; c <= n + 2; c++) begin
      tick();
      if (c == 2) check_vld({tag, "_fill_vld"}, 1'b0);
      if (c == 3) check_vld({tag, "_run_vld"}, 1'b1);
    end
    EN = 1'b0;
    @(posedge DIG_CLK);
    #1;
    check_idle({tag, "_en_drop"});
    tick();
  endtask

  always @(posedge DIG_CLK) begin
    #1;
    if (DCW_VLD === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_vld: got mmd=%h dtc=%h rt=%b, want no valid output",
                 MMD_DCW_X4, DTC_DCW_X4, RT_DCW_X4);
      end else begin
        mon_e = exp_q.pop_front();
        if (MMD_DCW_X4 !== mon_e.mmd || DTC_DCW_X4 !== mon_e.dtc || RT_DCW_X4 !== mon_e.rt) begin
          miscompares++;
          $display("FAIL %s: got mmd=%h dtc=%h rt=%b, want mmd=%h dtc=%h rt=%b", mon_e.tag,
                   MMD_DCW_X4, DTC_DCW_X4, RT_DCW_X4, mon_e.mmd, mon_e.dtc, mon_e.rt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, want self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    check_idle("reset");

    load(8, 'h0000, 1023, 512);
    run(mk(8, 8, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, "int_only"), 4, "int_only");

    load(8, 'h4000, 1023, 512);
    run(mk(8, 8, 8, 9, 255, 511, 767, 0, 0, 0, 1, 0, "quarter"), 4, "quarter");

    load(8, 'h4000, 1023, 511);
    run(mk(8, 8, 8, 9, 255, 511, 767, 0, 0, 1, 1, 0, "rt_equal"), 3, "rt_equal");

    load(8, 'h4000, 512, 256);
    run(mk(8, 8, 8, 9, 128, 256, 384, 0, 0, 1, 1, 0, "kdtc_half"), 3, "kdtc_half");

    load(127, 'h8000, 1023, 512);
    run(mk(127, 127, 127, 127, 511, 0, 511, 0, 0, 0, 0, 0, "sat_hi"), 3, "sat_hi");

    load(2, 'h0000, 1023, 512);
    run(mk(4, 4, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, "clamp_lo"), 3, "clamp_lo");

    // FRAC=0x2000 alternates acc 0 / 0x8000; reloading 0x4000 on an acc=0x8000
    // cycle must continue from 0x8000.
    load(8, 'h2000, 1023, 512);
    for (int unsigned i = 0; i < 5; i++) begin
      if (i % 2 == 0) exp_q.push_back(mk(8, 8, 8, 8, 127, 255, 383, 511, 0, 0, 0, 0, "cont_a"));
      else            exp_q.push_back(mk(8, 8, 8, 9, 639, 767, 895, 0, 1, 1, 1, 0, "cont_b"));
    end
    for (int unsigned i = 0; i < 3; i++)
      exp_q.push_back(mk(8, 9, 8, 8, 767, 0, 255, 511, 1, 0, 0, 0, "cont_new"));
    EN = 1'b1;
    for (int unsigned c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) check_vld("cont_fill_vld", 1'b0);
      if (c >= 3) check_vld("cont_run_vld", 1'b1);
      if (c == 5) begin
        FCW_FRAC = 16'h4000;
        FCW_LOAD = 1'b1;
      end
      if (c == 6) FCW_LOAD = 1'b0;
    end
    EN = 1'b0;
    @(posedge DIG_CLK);
    #1;
    check_idle("cont_en_drop");
    tick();

    run(mk(8, 8, 8, 9, 255, 511, 767, 0, 0, 0, 1, 0, "restart"), 3, "restart");

    // Reset mid-run also clears the shadow words: INT=0 clamps to 4, DTC=0 >= RT_TH=0.
    for (int unsigned i = 0; i < 3; i++)
      exp_q.push_back(mk(8, 8, 8, 9, 255, 511, 767, 0, 0, 0, 1, 0, "pre_rst"));
    EN = 1'b1;
    for (int unsigned c = 1; c <= 5; c++) tick();
    RST = 1'b1;
    @(posedge DIG_CLK);
    #1;
    check_idle("rst_mid");
    tick();
    RST = 1'b0;
    for (int unsigned i = 0; i < 3; i++)
      exp_q.push_back(mk(4, 4, 4, 4, 0, 0, 0, 0, 1, 1, 1, 1, "post_rst"));
    for (int unsigned c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) check_vld("post_rst_fill_vld", 1'b0);
      if (c == 3) check_vld("post_rst_run_vld", 1'b1);
    end
    EN = 1'b0;
    @(posedge DIG_CLK);
    #1;
    check_idle("post_rst_en_drop");
    tick();

    for (int unsigned i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending outputs, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
